quadrature_encoder_gen: RTL and testbench
=========================================

# quadrature_encoder_gen

Generates two-phase quadrature signals (A/B) for a commanded number of detents in a commanded direction. It is the transmit-side counterpart of the rotary quadrature decoder path. It emulates a mechanical rotary encoder, so the debounce, decode and event-detect chain can be driven in loopback on hardware and in simulation. It can also drive external quadrature-input devices. It runs on the system clock and has its own phase-rate divider.

## Interface
- PHASE_DIV, 8000: system clocks per quadrature transition (16 MHz / 8000 = 2 kHz transition rate); legal range ≥ 2.
- DIV_W, 16: divider counter width; must hold PHASE_DIV-1.
- CNT_W, 10: width of detent count.

- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  command strobe; sampled on rising edge of Clk.
- Dir  in  1  direction, latched with Start; 1 = CW (A leads B), 0 = CCW.
- Detents  in  CNT_W  number of detents to emit, latched with Start.
- Abort  in  1  level; requests early stop at the next detent boundary.
- Ready  out  1  high only in IDLE; command accepted when Start & Ready.
- Busy  out  1  inverse of Ready.
- Done  out  1  single-cycle pulse at command completion.
- A  out  1  quadrature phase A (registered).
- B  out  1  quadrature phase B (registered).
- Remaining  out  CNT_W  detents still to be emitted; includes the one in progress.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1 latches Dir and Detents and clears the divider.
  - Detents=0 → DONE directly; no edges are emitted.
  - Detents>0 → RUN.
- RUN:
  - The divider counts 0..PHASE_DIV-1. At terminal count it wraps to 0 and the phase advances one Gray step.
  - CW sequence AB: 00→10→11→01→00. CCW sequence: 00→01→11→10→00.
  - Exactly one of A/B changes per step. Outputs never glitch.
  - Each return to 00 ends one detent and decrements Remaining.
  - Remaining reaches 0 → DONE.
  - Abort=1 sampled on any cycle in RUN sets a sticky abort flag. At the next return to 00, RUN → DONE regardless of Remaining, and Remaining is cleared to 0.
  - A partial detent is never left on the outputs.
- DONE: Done=1 for one cycle, then → IDLE. The abort flag clears here.
- Start while Busy is ignored. Dir and Detents changes while Busy are ignored.
- Abort in IDLE or DONE is ignored.
- Rest state is AB=00 whenever not in RUN.
- Reset values: state IDLE, A=0, B=0, Ready=1, Busy=0, Done=0, Remaining=0, divider 0, abort flag 0.
- Reset asserted mid-RUN returns the outputs to rest immediately (asynchronously). The command is discarded and no Done is issued.

## Timing
- Accept edge = cycle 0. Transition k (k = 1..4N) appears on A/B at cycle k·PHASE_DIV.
- Final transition to 00 at cycle 4N·PHASE_DIV. Done is high during cycle 4N·PHASE_DIV+1. Ready returns at 4N·PHASE_DIV+2.
- Detents=0: Done is high in cycle 1 and Ready returns in cycle 2.
- Remaining updates on the same edge as the 01→00 (CW) or 10→00 (CCW) transition.
- Minimum spacing between accepted commands is 2 cycles after Done.

## Configuration
- QUAD_GEN_ACTIVE_LOW_EN defined: A and B are driven inverted, matching negative-logic encoder contacts with pull-ups.
  - Rest state is AB=11, and the reset value of A and B is 1.
  - Sequences are the bitwise complement of those listed above.
- Not defined: positive logic as specified above.
- Remaining, Done, Ready and the FSM are identical in both builds.

## Test plan
- Reset: assert Reset for 3 cycles → A=0, B=0, Ready=1, Busy=0, Done=0, Remaining=0. With QUAD_GEN_ACTIVE_LOW_EN, A=B=1.
- CW single detent (PHASE_DIV=4): Start, Dir=1, Detents=1 → AB=10@4, 11@8, 01@12, 00@16; Done high only in cycle 17; Ready=1 at cycle 18.
- CCW two detents (PHASE_DIV=4): Dir=0, Detents=2 → AB=01, 11, 10, 00 repeated twice at 4-cycle spacing; Remaining 2→1@16, 1→0@32; Done in cycle 33.
- Zero / ignored commands: Detents=0 → Done in cycle 1 with no A/B change. Start pulsed during a 3-detent run → no effect, Remaining unaffected.
- Abort: Detents=3, Abort pulsed at cycle 6 → first detent completes (00@16), Done in cycle 17, Remaining=0, no further edges.
- Reset mid-run and loopback: Reset at cycle 10 of a run → AB=00 immediately, no Done. A 5-detent CW run with PHASE_DIV=8000 looped into the decoder chain → display count increments by 5.

Source files
------------

// File: rtl/quadrature_encoder_gen.sv
// Quadrature A/B generator emulating a rotary encoder for a commanded number of detents.
// Optional build macro QUAD_GEN_ACTIVE_LOW_EN drives A/B inverted (rest state AB=11).
module quadrature_encoder_gen #(
    parameter int unsigned PHASE_DIV = 8000,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Dir,
    input  logic [CNT_W-1:0] Detents,
    input  logic             Abort,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic             A,
    output logic             B,
    output logic [CNT_W-1:0] Remaining
);

`ifdef QUAD_GEN_ACTIVE_LOW_EN
    localparam logic [1:0] AB_POL = 2'b11;
`else
    localparam logic [1:0] AB_POL = 2'b00;
`endif

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       step_q;
    logic [1:0]       ab_q;
    logic             dir_q;
    logic             abort_q;
    logic             last_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] remaining_q;

    logic             div_wrap;
    logic [1:0]       step_next;
    logic             abort_hit;

    // Step index 0..3 maps to the positive-logic AB pattern for the latched direction.
    function automatic logic [1:0] gray_ab(input logic [1:0] idx, input logic cw);
        logic [1:0] ab;
        ab = 2'b00;
        case (idx)
            2'd0: ab = 2'b00;
            2'd1: ab = cw ? 2'b10 : 2'b01;
            2'd2: ab = 2'b11;
            2'd3: ab = cw ? 2'b01 : 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    always_comb begin
        div_wrap  = (div_q == DIV_LAST);
        step_next = step_q + 2'd1;
        abort_hit = abort_q | Abort;
    end

    // last_q holds RUN for one extra cycle after the final 00, so Done lands one
    // cycle after the last edge and Ready one cycle after Done, also for Detents=0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            div_q       <= '0;
            step_q      <= '0;
            ab_q        <= AB_POL;
            dir_q       <= 1'b0;
            abort_q     <= 1'b0;
            last_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        dir_q       <= Dir;
                        remaining_q <= Detents;
                        div_q       <= '0;
                        step_q      <= '0;
                        abort_q     <= 1'b0;
                        last_q      <= (Detents == '0);
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (last_q) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (Abort) begin
                            abort_q <= 1'b1;
                        end
                        if (div_wrap) begin
                            div_q  <= '0;
                            step_q <= step_next;
                            ab_q   <= gray_ab(step_next, dir_q) ^ AB_POL;
                            if (step_q == 2'd3) begin
                                if (abort_hit) begin
                                    remaining_q <= '0;
                                    last_q      <= 1'b1;
                                end else begin
                                    remaining_q <= remaining_q - CNT_W'(1);
                                    last_q      <= (remaining_q == CNT_W'(1));
                                end
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    abort_q <= 1'b0;
                    last_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign A         = ab_q[1];
    assign B         = ab_q[0];
    assign Ready     = ready_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Remaining = remaining_q;

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Directed bench for quadrature_encoder_gen at PHASE_DIV=4 with hand-derived cycle timing.
module tb_quadrature_encoder_gen;

    localparam int unsigned PHASE_DIV = 4;
    localparam int unsigned DIV_W     = 4;
    localparam int unsigned CNT_W     = 10;

`ifdef QUAD_GEN_ACTIVE_LOW_EN
    localparam logic [1:0] TB_POL = 2'b11;
`else
    localparam logic [1:0] TB_POL = 2'b00;
`endif

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic             Dir;
    logic [CNT_W-1:0] Detents;
    logic             Abort;
    logic             Ready;
    logic             Busy;
    logic             Done;
    logic             A;
    logic             B;
    logic [CNT_W-1:0] Remaining;

    int checks = 0;
    int errors = 0;

    logic [1:0] cw_seq  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] ccw_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quadrature_encoder_gen #(
        .PHASE_DIV(PHASE_DIV),
        .DIV_W    (DIV_W),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Dir      (Dir),
        .Detents  (Detents),
        .Abort    (Abort),
        .Ready    (Ready),
        .Busy     (Busy),
        .Done     (Done),
        .A        (A),
        .B        (B),
        .Remaining(Remaining)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [1:0] ab_logical();
        return {A, B} ^ TB_POL;
    endfunction

    task automatic launch(input logic dir, input int unsigned n);
        Start   = 1'b1;
        Dir     = dir;
        Detents = CNT_W'(n);
        tick();
        Start   = 1'b0;
        Dir     = 1'b0;
        Detents = '0;
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        Dir     = 1'b0;
        Detents = '0;
        Abort   = 1'b0;

        // Reset held for three cycles
        tick(); tick(); tick();
        check("rst_ab",    32'({A, B}), 32'(TB_POL));
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_busy",  32'(Busy), 32'd0);
        check("rst_done",  32'(Done), 32'd0);
        check("rst_rem",   32'(Remaining), 32'd0);
        Reset = 1'b0;
        tick(); tick();
        check("idle_ab",    32'(ab_logical()), 32'd0);
        check("idle_ready", 32'(Ready), 32'd1);

        // CW single detent: 10@4 11@8 01@12 00@16, Done@17, Ready@18
        launch(1'b1, 1);
        check("cw1_c0_ready", 32'(Ready), 32'd0);
        check("cw1_c0_busy",  32'(Busy), 32'd1);
        check("cw1_c0_rem",   32'(Remaining), 32'd1);
        check("cw1_c0_ab",    32'(ab_logical()), 32'd0);
        for (int c = 1; c <= 18; c++) begin
            tick();
            check($sformatf("cw1_ab_c%0d", c), 32'(ab_logical()),
                  32'((c < 16) ? cw_seq[(c / 4) % 4] : 2'b00));
            check($sformatf("cw1_rem_c%0d", c), 32'(Remaining), (c < 16) ? 32'd1 : 32'd0);
            check($sformatf("cw1_done_c%0d", c), 32'(Done), (c == 17) ? 32'd1 : 32'd0);
            check($sformatf("cw1_ready_c%0d", c), 32'(Ready), (c >= 18) ? 32'd1 : 32'd0);
            check($sformatf("cw1_busy_c%0d", c), 32'(Busy), (c >= 18) ? 32'd0 : 32'd1);
        end

        // CCW two detents, with an ignored Start/Dir/Detents change mid-run
        launch(1'b0, 2);
        check("ccw2_c0_rem", 32'(Remaining), 32'd2);
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 20) begin
                Start   = 1'b1;
                Dir     = 1'b1;
                Detents = CNT_W'(7);
            end
            if (c == 21) begin
                Start   = 1'b0;
                Dir     = 1'b0;
                Detents = '0;
            end
            check($sformatf("ccw2_ab_c%0d", c), 32'(ab_logical()),
                  32'((c < 32) ? ccw_seq[(c / 4) % 4] : 2'b00));
            check($sformatf("ccw2_rem_c%0d", c), 32'(Remaining),
                  (c < 16) ? 32'd2 : ((c < 32) ? 32'd1 : 32'd0));
            check($sformatf("ccw2_done_c%0d", c), 32'(Done), (c == 33) ? 32'd1 : 32'd0);
            check($sformatf("ccw2_ready_c%0d", c), 32'(Ready), (c >= 34) ? 32'd1 : 32'd0);
        end

        // Zero detents: Done in cycle 1, Ready in cycle 2, no edges
        launch(1'b1, 0);
        check("zero_c0_ready", 32'(Ready), 32'd0);
        check("zero_c0_rem",   32'(Remaining), 32'd0);
        check("zero_c0_done",  32'(Done), 32'd0);
        tick();
        check("zero_c1_done",  32'(Done), 32'd1);
        check("zero_c1_ready", 32'(Ready), 32'd0);
        check("zero_c1_ab",    32'(ab_logical()), 32'd0);
        tick();
        check("zero_c2_done",  32'(Done), 32'd0);
        check("zero_c2_ready", 32'(Ready), 32'd1);
        check("zero_c2_ab",    32'(ab_logical()), 32'd0);

        // Abort sampled at edge 6 of a 3-detent CW run: stop at first 00 (cycle 16)
        launch(1'b1, 3);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 5) Abort = 1'b1;
            if (c == 6) Abort = 1'b0;
            check($sformatf("abt_ab_c%0d", c), 32'(ab_logical()),
                  32'((c < 16) ? cw_seq[(c / 4) % 4] : 2'b00));
            check($sformatf("abt_rem_c%0d", c), 32'(Remaining), (c < 16) ? 32'd3 : 32'd0);
            check($sformatf("abt_done_c%0d", c), 32'(Done), (c == 17) ? 32'd1 : 32'd0);
            check($sformatf("abt_ready_c%0d", c), 32'(Ready), (c >= 18) ? 32'd1 : 32'd0);
        end

        // Abort while idle is ignored by the next command
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        launch(1'b1, 1);
        for (int c = 1; c <= 17; c++) tick();
        check("idleabt_done_c17", 32'(Done), 32'd1);
        check("idleabt_rem_c17",  32'(Remaining), 32'd0);
        tick();

        // Reset mid-run returns AB to rest without a clock edge and issues no Done
        launch(1'b1, 2);
        for (int c = 1; c <= 10; c++) tick();
        check("mrst_ab_c10", 32'(ab_logical()), 32'(2'b11));
        Reset = 1'b1;
        #1;
        check("mrst_ab_async",    32'(ab_logical()), 32'd0);
        check("mrst_ready_async", 32'(Ready), 32'd1);
        check("mrst_busy_async",  32'(Busy), 32'd0);
        check("mrst_rem_async",   32'(Remaining), 32'd0);
        tick(); tick();
        Reset = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            check($sformatf("mrst_done_c%0d", c), 32'(Done), 32'd0);
            check($sformatf("mrst_ab_c%0d", c), 32'(ab_logical()), 32'd0);
        end

        // Back-to-back command accepted as soon as Ready returns
        launch(1'b0, 1);
        for (int c = 1; c <= 18; c++) tick();
        check("b2b_ready_c18", 32'(Ready), 32'd1);
        launch(1'b1, 0);
        check("b2b_c0_busy", 32'(Busy), 32'd1);
        tick();
        check("b2b_c1_done", 32'(Done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
